// File: rtl/sram_arb_pkg.sv
// Shared types and helpers for the SRAM port arbiter.
// Used by sram_port_arbiter and sram_arb_rsp_pipe.
package sram_arb_pkg;

  // Wide enough for up to 8 requesters.
  localparam int ID_W = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            err;
  } rsp_pipe_t;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_t;

  // First set index at or after ptr, wrapping at n.
  function automatic logic [ID_W-1:0] rr_pick(
    input logic [7:0]      valid,
    input logic [ID_W-1:0] ptr,
    input int              n
  );
    int j;
    rr_pick = ptr;
    for (int k = 7; k >= 0; k--) begin
      j = int'(ptr) + k;
      if (j >= n) j = j - n;
      if (k < n && valid[j[2:0]])
        rr_pick = j[ID_W-1:0];
    end
  endfunction

endpackage

// File: rtl/sram_arb_rsp_pipe.sv
// Delay line carrying read-response routing info
// alongside the SRAM read latency.
module sram_arb_rsp_pipe
  import sram_arb_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic      clk,
  input  logic      rst,
  input  rsp_pipe_t in_ent,
  output rsp_pipe_t out_ent
);

  rsp_pipe_t pipe_q [DEPTH];
  rsp_pipe_t pipe_d [DEPTH];

  // Shift each entry one stage per cycle.
  always_comb begin
    pipe_d[0] = in_ent;
    for (int s = 1; s < DEPTH; s++)
      pipe_d[s] = pipe_q[s-1];
  end

  // Reset drops every response in flight.
  always_ff @(posedge clk) begin
    for (int s = 0; s < DEPTH; s++) begin
      if (!rst) pipe_q[s] <= '0;
      else      pipe_q[s] <= pipe_d[s];
    end
  end

  assign out_ent = pipe_q[DEPTH-1];

endmodule

// File: rtl/sram_port_arbiter.sv
// Shares one single-port SRAM among NUM_REQ requesters.
// Optional counters: define SRAM_ARB_STATS_EN.
module sram_port_arbiter
  import sram_arb_pkg::*;
#(
  parameter int NUM_REQ   = 3,
  parameter int ADDR_W    = 30,
  parameter int SRAM_AW   = 10,
  parameter int NUM_WORDS = 1024,
  parameter int DATA_W    = 32,
  parameter int RD_LAT    = 1,
  parameter int PRIO0     = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         IN_req_valid,
  input  logic [NUM_REQ-1:0]         IN_req_we,
  input  logic [NUM_REQ-1:0]         IN_req_lock,
  input  logic [NUM_REQ*ADDR_W-1:0]  IN_req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]  IN_req_data,
  input  logic [NUM_REQ*DATA_W/8-1:0] IN_req_wm,
  output logic [NUM_REQ-1:0]         OUT_req_ready,
  output logic [NUM_REQ-1:0]         OUT_rsp_valid,
  output logic                       OUT_rsp_err,
  output logic [DATA_W-1:0]          OUT_rsp_data,
  output logic                       OUT_SRAM_nce,
  output logic                       OUT_SRAM_nwe,
  output logic [SRAM_AW-1:0]         OUT_SRAM_addr,
  output logic [DATA_W-1:0]          OUT_SRAM_data,
  output logic [DATA_W/8-1:0]        OUT_SRAM_wm,
  input  logic [DATA_W-1:0]          IN_SRAM_data
`ifdef SRAM_ARB_STATS_EN
  ,
  output logic [NUM_REQ*32-1:0]      OUT_stat_grants,
  output logic [NUM_REQ*32-1:0]      OUT_stat_stalls,
  output logic [31:0]                OUT_stat_oor
`endif
);

  localparam int MW = DATA_W / 8;

  arb_state_t state_q, state_d;
  logic [ID_W-1:0] ptr_q, ptr_d;
  logic [ID_W-1:0] owner_q, owner_d;
  logic [7:0]      valid8;
  logic [ID_W-1:0] gnt_id;
  logic            gnt_any;

  logic              sel_we, sel_lock, in_range;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_data;
  logic [MW-1:0]     sel_wm;

  logic              nce_q, nce_d, nwe_q, nwe_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [MW-1:0]     wm_q, wm_d;

  rsp_pipe_t pipe_in, pipe_out;

  // Pick the winner; nothing is granted while in reset.
  always_comb begin
    valid8 = '0;
    valid8[NUM_REQ-1:0] = IN_req_valid;
    gnt_id  = '0;
    gnt_any = 1'b0;
    unique case (state_q)
      LOCKED: begin
        gnt_id  = owner_q;
        gnt_any = valid8[owner_q];
      end
      IDLE: begin
        gnt_any = |IN_req_valid;
        if (PRIO0 != 0 && IN_req_valid[0])
          gnt_id = '0;
        else
          gnt_id = rr_pick(valid8, ptr_q, NUM_REQ);
      end
    endcase
    gnt_any = gnt_any & rst;
    for (int i = 0; i < NUM_REQ; i++)
      OUT_req_ready[i] = gnt_any && (gnt_id == ID_W'(i));
  end

  // Mux the granted beat.
  always_comb begin
    sel_we   = 1'b0;
    sel_lock = 1'b0;
    sel_addr = '0;
    sel_data = '0;
    sel_wm   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (OUT_req_ready[i]) begin
        sel_we   = IN_req_we[i];
        sel_lock = IN_req_lock[i];
        sel_addr = IN_req_addr[i*ADDR_W +: ADDR_W];
        sel_data = IN_req_data[i*DATA_W +: DATA_W];
        sel_wm   = IN_req_wm[i*MW +: MW];
      end
    end
    in_range = sel_addr < ADDR_W'(NUM_WORDS);
  end

  // Pointer and lock ownership follow every fired beat.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    if (gnt_any) begin
      if (gnt_id == ID_W'(NUM_REQ-1)) ptr_d = '0;
      else                            ptr_d = gnt_id + ID_W'(1);
      if (sel_lock) begin
        state_d = LOCKED;
        owner_d = gnt_id;
      end else begin
        state_d = IDLE;
      end
    end
  end

  // SRAM strobes pulse for one cycle; address and data hold.
  always_comb begin
    nce_d  = 1'b1;
    nwe_d  = 1'b1;
    addr_d = addr_q;
    data_d = data_q;
    wm_d   = wm_q;
    if (gnt_any && in_range) begin
      nce_d  = 1'b0;
      nwe_d  = ~sel_we;
      addr_d = sel_addr[SRAM_AW-1:0];
      data_d = sel_data;
      wm_d   = sel_wm;
    end
  end

  // Arbitration state and registered SRAM drive.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      owner_q <= '0;
      nce_q   <= 1'b1;
      nwe_q   <= 1'b1;
      addr_q  <= '0;
      data_q  <= '0;
      wm_q    <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      owner_q <= owner_d;
      nce_q   <= nce_d;
      nwe_q   <= nwe_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wm_q    <= wm_d;
    end
  end

  assign OUT_SRAM_nce  = nce_q;
  assign OUT_SRAM_nwe  = nwe_q;
  assign OUT_SRAM_addr = addr_q;
  assign OUT_SRAM_data = data_q;
  assign OUT_SRAM_wm   = wm_q;

  // Every read, in range or not, gets a routed response.
  always_comb begin
    pipe_in.valid = gnt_any && !sel_we;
    pipe_in.id    = gnt_id;
    pipe_in.err   = !in_range;
  end

  sram_arb_rsp_pipe #(
    .DEPTH (RD_LAT + 1)
  ) u_rsp_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_ent  (pipe_in),
    .out_ent (pipe_out)
  );

  // Route the response; data reads zero unless a good read lands.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++)
      OUT_rsp_valid[i] = pipe_out.valid && (pipe_out.id == ID_W'(i));
    OUT_rsp_err  = pipe_out.valid && pipe_out.err;
    OUT_rsp_data = (pipe_out.valid && !pipe_out.err) ? IN_SRAM_data : '0;
  end

`ifdef SRAM_ARB_STATS_EN
  logic [NUM_REQ*32-1:0] grants_q, grants_d;
  logic [NUM_REQ*32-1:0] stalls_q, stalls_d;
  logic [31:0]           oor_q, oor_d;

  // Free-running wrap-around event counters.
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      grants_d[i*32 +: 32] = grants_q[i*32 +: 32] + 32'(OUT_req_ready[i]);
      stalls_d[i*32 +: 32] = stalls_q[i*32 +: 32]
                           + 32'(IN_req_valid[i] & ~OUT_req_ready[i]);
    end
    oor_d = oor_q + 32'(gnt_any & ~in_range);
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (!rst) begin
      grants_q <= '0;
      stalls_q <= '0;
      oor_q    <= '0;
    end else begin
      grants_q <= grants_d;
      stalls_q <= stalls_d;
      oor_q    <= oor_d;
    end
  end

  assign OUT_stat_grants = grants_q;
  assign OUT_stat_stalls = stalls_q;
  assign OUT_stat_oor    = oor_q;
`endif

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Testbench for sram_port_arbiter: directed table, corner
// sequences and random traffic against a behavioural model.
module tb_sram_port_arbiter;

  localparam int N   = 3;
  localparam int AW  = 30;
  localparam int DW  = 32;
  localparam int NW  = 1024;
  localparam int LAT = 3;
  localparam int P0  = 1;

  logic clk, rst;
  logic [N-1:0]      valid, we, lock;
  logic [N*AW-1:0]   addr;
  logic [N*DW-1:0]   wdata;
  logic [N*4-1:0]    wm;
  logic [N-1:0]      ready, rsp_valid;
  logic              rsp_err;
  logic [DW-1:0]     rsp_data;
  logic              nce, nwe;
  logic [9:0]        saddr;
  logic [DW-1:0]     sdata, srdata;
  logic [3:0]        swm;

  sram_port_arbiter #(
    .NUM_REQ(N), .ADDR_W(AW), .SRAM_AW(10), .NUM_WORDS(NW),
    .DATA_W(DW), .RD_LAT(LAT), .PRIO0(P0)
  ) dut (
    .clk(clk), .rst(rst),
    .IN_req_valid(valid), .IN_req_we(we), .IN_req_lock(lock),
    .IN_req_addr(addr), .IN_req_data(wdata), .IN_req_wm(wm),
    .OUT_req_ready(ready), .OUT_rsp_valid(rsp_valid),
    .OUT_rsp_err(rsp_err), .OUT_rsp_data(rsp_data),
    .OUT_SRAM_nce(nce), .OUT_SRAM_nwe(nwe), .OUT_SRAM_addr(saddr),
    .OUT_SRAM_data(sdata), .OUT_SRAM_wm(swm), .IN_SRAM_data(srdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model
  logic [DW-1:0] smem [NW];
  logic [DW-1:0] srd [LAT];
  assign srdata = srd[LAT-1];

  always @(posedge clk) begin
    logic [DW-1:0] rv;
    rv = $urandom;
    if (!nce && nwe) rv = smem[saddr];
    if (!nce && !nwe)
      for (int b = 0; b < 4; b++)
        if (swm[b]) smem[saddr][b*8 +: 8] = sdata[b*8 +: 8];
    srd[0] <= rv;
    for (int s = 1; s < LAT; s++) srd[s] <= srd[s-1];
  end

  // Reference model
  typedef struct {
    int          due;
    int          id;
    bit          err;
    logic [31:0] data;
  } rsp_t;

  rsp_t          q[$];
  logic [DW-1:0] rmem [NW];
  int            ptr, own, cyc;
  bit            lk;
  logic          e_nce, e_nwe;
  logic [9:0]    e_addr;
  logic [31:0]   e_data;
  logic [3:0]    e_wm;
  int            total, bad;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
    end
  endtask

  task automatic model_reset();
    ptr = 0; lk = 0; own = 0;
    q.delete();
    e_nce = 1; e_nwe = 1; e_addr = '0; e_data = '0; e_wm = '0;
  endtask

  // One cycle: inputs are set at the negedge before the call.
  task automatic step();
    int g;
    bit any, inr;
    logic [2:0] er, erv;
    logic [AW-1:0] a;
    logic eerr;
    logic [31:0] edat;
    #1;
    any = 0; g = 0;
    if (rst) begin
      if (lk) begin
        any = valid[own]; g = own;
      end else if (P0 != 0 && valid[0]) begin
        any = 1; g = 0;
      end else begin
        for (int k = 0; k < N; k++) begin
          int j;
          j = (ptr + k) % N;
          if (!any && valid[j]) begin any = 1; g = j; end
        end
      end
    end
    er = any ? 3'(1 << g) : 3'b000;
    chk("ready", 32'(ready), 32'(er));
    erv = '0; eerr = 0; edat = '0;
    if (q.size() > 0 && q[0].due == cyc) begin
      erv = 3'(1 << q[0].id);
      eerr = q[0].err;
      edat = q[0].data;
      void'(q.pop_front());
    end
    chk("rsp_valid", 32'(rsp_valid), 32'(erv));
    chk("rsp_err", 32'(rsp_err), 32'(eerr));
    chk("rsp_data", rsp_data, edat);
    chk("nce", 32'(nce), 32'(e_nce));
    chk("nwe", 32'(nwe), 32'(e_nwe));
    chk("sram_addr", 32'(saddr), 32'(e_addr));
    chk("sram_data", sdata, e_data);
    chk("sram_wm", 32'(swm), 32'(e_wm));
    @(posedge clk);
    if (!rst) begin
      model_reset();
    end else begin
      e_nce = 1; e_nwe = 1;
      if (any) begin
        a = addr[g*AW +: AW];
        inr = a < AW'(NW);
        if (we[g]) begin
          if (inr)
            for (int b = 0; b < 4; b++)
              if (wm[g*4+b]) rmem[a[9:0]][b*8 +: 8] = wdata[g*DW+b*8 +: 8];
        end else begin
          q.push_back('{cyc + 1 + LAT, g, !inr, inr ? rmem[a[9:0]] : 32'h0});
        end
        if (inr) begin
          e_nce = 0; e_nwe = !we[g]; e_addr = a[9:0];
          e_data = wdata[g*DW +: DW]; e_wm = wm[g*4 +: 4];
        end
        ptr = (g + 1) % N;
        lk = lock[g];
        own = g;
      end
    end
    cyc++;
    @(negedge clk);
  endtask

  task automatic clr();
    valid = '0; we = '0; lock = '0;
  endtask

  task automatic set_req(int i, bit w, bit l, logic [AW-1:0] a,
                         logic [31:0] d, logic [3:0] m);
    valid[i] = 1'b1; we[i] = w; lock[i] = l;
    addr[i*AW +: AW] = a;
    wdata[i*DW +: DW] = d;
    wm[i*4 +: 4] = m;
  endtask

  typedef struct {
    bit         r;
    logic [2:0] v, w, l, er;
  } vec_t;

  vec_t tv [20];

  initial begin
    total = 0; bad = 0; cyc = 0;
    for (int i = 0; i < NW; i++) begin smem[i] = '0; rmem[i] = '0; end
    // rows: reset, burst lock with idle gap, RR, lock ignored, req0 lock
    tv[0]  = '{0, 3'b111, 3'b000, 3'b000, 3'b000};
    tv[1]  = '{0, 3'b111, 3'b000, 3'b000, 3'b000};
    tv[2]  = '{0, 3'b111, 3'b000, 3'b000, 3'b000};
    tv[3]  = '{1, 3'b111, 3'b000, 3'b000, 3'b001};
    tv[4]  = '{1, 3'b100, 3'b100, 3'b100, 3'b100};
    tv[5]  = '{1, 3'b111, 3'b100, 3'b100, 3'b100};
    tv[6]  = '{1, 3'b011, 3'b000, 3'b000, 3'b000};
    tv[7]  = '{1, 3'b111, 3'b100, 3'b100, 3'b100};
    tv[8]  = '{1, 3'b111, 3'b100, 3'b000, 3'b100};
    tv[9]  = '{1, 3'b011, 3'b000, 3'b000, 3'b001};
    tv[10] = '{1, 3'b110, 3'b000, 3'b000, 3'b010};
    tv[11] = '{1, 3'b110, 3'b000, 3'b000, 3'b100};
    tv[12] = '{1, 3'b110, 3'b000, 3'b000, 3'b010};
    tv[13] = '{1, 3'b101, 3'b000, 3'b100, 3'b001};
    tv[14] = '{1, 3'b110, 3'b000, 3'b000, 3'b010};
    tv[15] = '{1, 3'b011, 3'b000, 3'b001, 3'b001};
    tv[16] = '{1, 3'b010, 3'b000, 3'b000, 3'b000};
    tv[17] = '{1, 3'b011, 3'b000, 3'b000, 3'b001};
    tv[18] = '{1, 3'b010, 3'b000, 3'b000, 3'b010};
    tv[19] = '{1, 3'b000, 3'b000, 3'b000, 3'b000};

    rst = 0; clr(); addr = '0; wdata = '0; wm = '0;
    @(posedge clk);
    model_reset();
    @(negedge clk);

    for (int i = 0; i < 20; i++) begin
      rst = tv[i].r; valid = tv[i].v; we = tv[i].w; lock = tv[i].l;
      for (int k = 0; k < N; k++) begin
        addr[k*AW +: AW] = AW'(10 * k + i);
        wdata[k*DW +: DW] = $urandom;
        wm[k*4 +: 4] = 4'(k + i + 1);
      end
      #1;
      chk($sformatf("tbl_ready[%0d]", i), 32'(ready), 32'(tv[i].er));
      if (i == 3) begin
        chk("rst_nce", 32'(nce), 32'h1);
        chk("rst_addr", 32'(saddr), 32'h0);
        chk("rst_wm", 32'(swm), 32'h0);
        chk("rst_rsp", 32'(rsp_valid), 32'h0);
      end
      step();
    end
    clr();
    repeat (5) step();

    // out of range read, then write, then boundary words
    set_req(1, 0, 0, 30'h3f800000, 32'h0, 4'h0); step();
    clr();
    chk("oor_rd_nce", 32'(nce), 32'h1);
    repeat (3) step();
    chk("oor_rsp_valid", 32'(rsp_valid), 32'b010);
    chk("oor_rsp_err", 32'(rsp_err), 32'h1);
    chk("oor_rsp_data", rsp_data, 32'h0);
    set_req(2, 1, 0, 30'h3f800000, 32'hffffffff, 4'hf); step();
    clr();
    chk("oor_wr_nce", 32'(nce), 32'h1);
    set_req(0, 0, 0, 30'd1024, 32'h0, 4'h0); step();
    set_req(0, 1, 0, 30'd1023, 32'h12345678, 4'hf); step();
    set_req(0, 0, 0, 30'd1023, 32'h0, 4'h0); step();
    set_req(0, 0, 0, 30'd0, 32'h0, 4'h0); step();
    clr();
    repeat (5) step();
    chk("oor_mem0", smem[0], 32'h0);

    // write then read same word
    set_req(1, 1, 0, 30'd5, 32'hDEADBEEF, 4'b0011); step();
    set_req(1, 0, 0, 30'd5, 32'h0, 4'h0); step();
    clr();
    repeat (3) step();
    chk("wr_rd_valid", 32'(rsp_valid), 32'b010);
    chk("wr_rd_data", rsp_data, 32'h0000BEEF);
    repeat (2) step();

    // reset while a read is in flight
    set_req(0, 0, 0, 30'd7, 32'h0, 4'h0); step();
    clr(); step();
    rst = 0; step();
    rst = 1; step();
    chk("rst_drop", 32'(rsp_valid), 32'h0);
    step();
    set_req(2, 0, 0, 30'd24, 32'h0, 4'h0); step();
    clr();
    repeat (3) step();
    chk("post_rst_rsp", 32'(rsp_valid), 32'b100);
    repeat (2) step();

    // random traffic
    for (int c = 0; c < 3000; c++) begin
      rst = ($urandom_range(0, 299) != 0);
      for (int k = 0; k < N; k++) begin
        logic [AW-1:0] a;
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 7)       a = AW'($urandom_range(0, 63));
        else if (sel < 9)  a = AW'($urandom_range(1021, 1026));
        else               a = AW'($urandom);
        valid[k] = ($urandom_range(0, 2) != 0);
        we[k] = $urandom_range(0, 1);
        lock[k] = ($urandom_range(0, 3) == 0);
        addr[k*AW +: AW] = a;
        wdata[k*DW +: DW] = $urandom;
        wm[k*4 +: 4] = 4'($urandom);
      end
      step();
    end
    rst = 1; clr();
    repeat (8) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
